key_conditioner: RTL and testbench

Conditions raw active-low board push-buttons (KEYs) into clean, clock-synchronous control signals for the adder datapath control unit. Each key gets a two-flop synchronizer, a per-key debounce state machine, and edge detection. Outputs are a debounced active-high level plus single-cycle press/release pulses. The block sits directly upstream of the datapath and replaces its raw inline button inversion, so Run and Load_B pulses arrive exactly once per physical press.

---
 rtl/key_conditioner.sv | 145 ++++++++++++++
 tb/tb_key_conditioner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Per-key synchronizer, debounce FSM and press/release pulse generation for active-low push-buttons.
// Optional auto-repeat of Key_press while held: define KEY_CONDITIONER_AUTOREPEAT_EN.
module key_conditioner #(
  parameter int unsigned NUM_KEYS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] Key_n,
  output logic [NUM_KEYS-1:0] Key_level,
  output logic [NUM_KEYS-1:0] Key_press,
  output logic [NUM_KEYS-1:0] Key_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The entry sample counts as the first stable one, so the last accepted count is one short.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_conditioner: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  state_t              state [NUM_KEYS];
  logic [CNT_W-1:0]    cnt   [NUM_KEYS];

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]    rpt_cnt   [NUM_KEYS];
  logic [NUM_KEYS-1:0] rpt_phase;
`endif

  // Two-flop synchronizer, idles at released (1).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= Key_n;
      sync2 <= sync1;
    end
  end

  // Debounce FSMs, one per key, with registered level and pulse outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state[k] <= IDLE;
        cnt[k]   <= '0;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
        rpt_cnt[k] <= '0;
`endif
      end
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
      rpt_phase <= '0;
`endif
      Key_level   <= '0;
      Key_press   <= '0;
      Key_release <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        Key_press[k]   <= 1'b0;
        Key_release[k] <= 1'b0;
        case (state[k])
          IDLE: begin
            if (!sync2[k]) begin
              state[k] <= PRESS_WAIT;
              cnt[k]   <= CNT_W'(1);
            end else begin
              cnt[k] <= '0;
            end
          end
          PRESS_WAIT: begin
            if (sync2[k]) begin
              state[k] <= IDLE;
              cnt[k]   <= '0;
            end else if (cnt[k] == CNT_LAST) begin
              state[k]     <= HELD;
              cnt[k]       <= '0;
              Key_press[k] <= 1'b1;
              Key_level[k] <= 1'b1;
            end else begin
              cnt[k] <= cnt[k] + CNT_W'(1);
            end
          end
          HELD: begin
            if (sync2[k]) begin
              state[k] <= RELEASE_WAIT;
              cnt[k]   <= CNT_W'(1);
            end
          end
          RELEASE_WAIT: begin
            if (!sync2[k]) begin
              state[k] <= HELD;
              cnt[k]   <= '0;
            end else if (cnt[k] == CNT_LAST) begin
              state[k]       <= IDLE;
              cnt[k]         <= '0;
              Key_release[k] <= 1'b1;
              Key_level[k]   <= 1'b0;
            end else begin
              cnt[k] <= cnt[k] + CNT_W'(1);
            end
          end
          default: begin
            state[k] <= IDLE;
            cnt[k]   <= '0;
          end
        endcase
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
        // Repeat timer runs from the accepted press; a pulse landing on the release edge is dropped.
        if (state[k] == HELD || state[k] == RELEASE_WAIT) begin
          if (rpt_cnt[k] == (rpt_phase[k] ? PERIOD_LAST : DELAY_LAST)) begin
            rpt_cnt[k]   <= '0;
            rpt_phase[k] <= 1'b1;
            if (!(state[k] == RELEASE_WAIT && sync2[k] && cnt[k] == CNT_LAST)) begin
              Key_press[k] <= 1'b1;
            end
          end else begin
            rpt_cnt[k] <= rpt_cnt[k] + RPT_W'(1);
          end
        end else begin
          rpt_cnt[k]   <= '0;
          rpt_phase[k] <= 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: run-length debounce model checked every cycle plus literal pins.
module tb_key_conditioner;

  localparam int unsigned NK  = 3;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 3;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic          Clk;
  logic          Reset;
  logic [NK-1:0] Key_n;
  logic [NK-1:0] Key_level;
  logic [NK-1:0] Key_press;
  logic [NK-1:0] Key_release;

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Key_n      (Key_n),
    .Key_level  (Key_level),
    .Key_press  (Key_press),
    .Key_release(Key_release)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a key's level flips after DEB consecutive synchronized samples that disagree with it.
  logic [NK-1:0] p1, p2, s;
  logic [NK-1:0] m_level, m_press, m_rel;
  int run [NK];
  int age [NK];

  always @(posedge Clk) begin
    if (Reset) begin
      p1 = '1; p2 = '1;
      m_level = '0; m_press = '0; m_rel = '0;
      for (int k = 0; k < NK; k++) begin
        run[k] = 0;
        age[k] = 0;
      end
    end else begin
      s  = p2;
      p2 = p1;
      p1 = Key_n;
      for (int k = 0; k < NK; k++) begin
        m_press[k] = 1'b0;
        m_rel[k]   = 1'b0;
        if (m_level[k]) age[k]++;
        if (s[k] == m_level[k]) begin
          run[k]++;
          if (run[k] == DEB) begin
            run[k] = 0;
            if (m_level[k]) m_rel[k] = 1'b1;
            else begin
              m_press[k] = 1'b1;
              age[k] = 0;
            end
            m_level[k] = ~m_level[k];
          end
        end else begin
          run[k] = 0;
        end
        if (AUTOREPEAT && m_level[k] && !m_press[k] && age[k] >= RD && ((age[k] - RD) % RP) == 0)
          m_press[k] = 1'b1;
      end
    end
  end

  int pcnt [NK];
  int rcnt [NK];

  always @(negedge Clk) begin
    if (chk_en) begin
      check("level", Key_level, m_level);
      check("press", Key_press, m_press);
      check("release", Key_release, m_rel);
      for (int k = 0; k < NK; k++) begin
        if (Key_press[k]) pcnt[k]++;
        if (Key_release[k]) rcnt[k]++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  int snap_p, snap_r;

  initial begin
    for (int k = 0; k < NK; k++) begin
      pcnt[k] = 0;
      rcnt[k] = 0;
    end
    Reset = 1'b1;
    Key_n = '1;
    step(2);
    chk_en = 1'b1;
    check("rst_level", Key_level, 3'b000);
    check("rst_press", Key_press, 3'b000);
    check("rst_release", Key_release, 3'b000);

    // Clean press on key 0
    Reset = 1'b0;
    Key_n = 3'b110;
    step(5);
    check("clean_pre_press", Key_press, 3'b000);
    step(1);
    check("clean_press", Key_press, 3'b001);
    check("clean_level", Key_level, 3'b001);
    step(1);
    check("clean_press_clear", Key_press, 3'b000);
    check("clean_level_hold", Key_level, 3'b001);

    // Glitch on key 1 shorter than the debounce window
    Key_n = 3'b100;
    step(3);
    Key_n = 3'b110;
    step(10);
    check("glitch_level", Key_level, 3'b001);
    check_int("glitch_press_cnt", pcnt[1], 0);

    // Bouncy release of key 0
    Key_n = 3'b111; step(1);
    Key_n = 3'b110; step(1);
    Key_n = 3'b111;
    step(5);
    check("bounce_pre_release", Key_release, 3'b000);
    check("bounce_pre_level", Key_level, 3'b001);
    step(1);
    check("bounce_release", Key_release, 3'b001);
    check("bounce_level", Key_level, 3'b000);
    step(3);
    check_int("bounce_release_cnt", rcnt[0], 1);

    // All keys together
    Key_n = 3'b000;
    step(5);
    check("simul_pre_press", Key_press, 3'b000);
    step(1);
    check("simul_press", Key_press, 3'b111);
    check("simul_level", Key_level, 3'b111);
    step(1);
    check("simul_press_clear", Key_press, 3'b000);
    Key_n = 3'b111;
    step(10);
    check("simul_released", Key_level, 3'b000);
    check_int("simul_release_cnt2", rcnt[2], 1);

    // Reset during debounce of key 2, key kept held
    snap_p = pcnt[2];
    Key_n = 3'b011;
    step(3);
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    check("rstmid_level", Key_level, 3'b000);
    check("rstmid_press", Key_press, 3'b000);
    step(5);
    check("rstmid_pre_press", Key_press, 3'b000);
    step(1);
    check("rstmid_press_after", Key_press, 3'b100);
    check("rstmid_level_after", Key_level, 3'b100);
    Key_n = 3'b111;
    step(10);
    check_int("rstmid_press_cnt", pcnt[2] - snap_p, 1);

    // Long hold of key 0: one press, or press plus repeats when enabled
    snap_p = pcnt[0];
    snap_r = rcnt[0];
    Key_n = 3'b110;
    step(30);
    Key_n = 3'b111;
    step(12);
    check_int("hold_press_cnt", pcnt[0] - snap_p, AUTOREPEAT ? 8 : 1);
    check_int("hold_release_cnt", rcnt[0] - snap_r, 1);
    check("hold_final_level", Key_level, 3'b000);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
